// File: rtl/fetch_stage_if.sv
// Signal bundle between the IF stage and its neighbours: hazard/EX controls,
// the instruction-memory port and the IF/ID register outputs.
interface fetch_stage_if;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pcsrc_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misalign_err;
    logic        oob_err;
    logic [31:0] fetch_count;

    // Fetch-stage view.
    modport master (
        input  stall_f, stall_d, flush_d, pcsrc_e, pc_target_e, imem_rd,
        output imem_a, instr_d, pc_d, pc_plus4_d, valid_d,
        output misalign_err, oob_err, fetch_count
    );

    // Pipeline / memory view.
    modport slave (
        output stall_f, stall_d, flush_d, pcsrc_e, pc_target_e, imem_rd,
        input  imem_a, instr_d, pc_d, pc_plus4_d, valid_d,
        input  misalign_err, oob_err, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, IF/ID register, redirect and
// stall handling, sticky misalign / out-of-range flags and a fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           reset,
    fetch_stage_if.master  bus
);

    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        oob_f;
    logic        bubble_d;
    logic        load_d;

    assign bus.imem_a = pc_f;
    assign pc_plus4_f = pc_f + 32'd4;
    assign oob_f      = (pc_f[31:2] >= 30'(IMEM_WORDS));

    // A taken redirect squashes the wrong-path instruction even if ID is stalled.
    assign bubble_d = bus.flush_d | bus.pcsrc_e;
    assign load_d   = !bubble_d && !bus.stall_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f             <= RESET_PC;
            bus.instr_d      <= NOP_INSTR;
            bus.pc_d         <= 32'd0;
            bus.pc_plus4_d   <= 32'd0;
            bus.valid_d      <= 1'b0;
            bus.misalign_err <= 1'b0;
            bus.oob_err      <= 1'b0;
            bus.fetch_count  <= 32'd0;
        end else begin
            if (bus.pcsrc_e) begin
                pc_f <= {bus.pc_target_e[31:2], 2'b00};
                if (bus.pc_target_e[1:0] != 2'b00)
                    bus.misalign_err <= 1'b1;
            end else if (!bus.stall_f) begin
                pc_f <= pc_plus4_f;
            end

            if (bubble_d) begin
                bus.instr_d    <= NOP_INSTR;
                bus.pc_d       <= pc_f;
                bus.pc_plus4_d <= pc_plus4_f;
                bus.valid_d    <= 1'b0;
            end else if (load_d) begin
                bus.instr_d    <= oob_f ? NOP_INSTR : bus.imem_rd;
                bus.pc_d       <= pc_f;
                bus.pc_plus4_d <= pc_plus4_f;
                bus.valid_d    <= !oob_f;
                if (oob_f)
                    bus.oob_err <= 1'b1;
                else
                    bus.fetch_count <= bus.fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 64-word combinational instruction memory.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;
    logic [31:0] mem [64];

    fetch_stage_if bus();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Out-of-range addresses return garbage so NOP substitution is visible.
    assign bus.imem_rd = (bus.imem_a[31:8] == 24'd0) ? mem[bus.imem_a[7:2]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd,
                         input logic pc, input logic [31:0] tgt);
        bus.stall_f     = sf;
        bus.stall_d     = sd;
        bus.flush_d     = fd;
        bus.pcsrc_e     = pc;
        bus.pc_target_e = tgt;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_imem_a"}, bus.imem_a, 32'h0);
        check({tag, "_instr"},  bus.instr_d, NOP);
        check({tag, "_pc_d"},   bus.pc_d, 32'h0);
        check({tag, "_pc4_d"},  bus.pc_plus4_d, 32'h0);
        check({tag, "_valid"},  {31'd0, bus.valid_d}, 32'd0);
        check({tag, "_mis"},    {31'd0, bus.misalign_err}, 32'd0);
        check({tag, "_oob"},    {31'd0, bus.oob_err}, 32'd0);
        check({tag, "_cnt"},    bus.fetch_count, 32'd0);
    endtask

    initial begin
        mem[0] = 32'h7FF0_0F13;
        mem[1] = 32'h00D0_0E13;
        for (int k = 2; k < 64; k++) mem[k] = 32'hA000_0000 | 32'(k);

        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        step(); step();
        check_reset_state("rst");

        // Sequential fetch
        reset = 1'b0;
        step();
        check("seq1_instr", bus.instr_d, 32'h7FF0_0F13);
        check("seq1_pc_d", bus.pc_d, 32'h0);
        check("seq1_pc4_d", bus.pc_plus4_d, 32'h4);
        check("seq1_valid", {31'd0, bus.valid_d}, 32'd1);
        step();
        check("seq2_instr", bus.instr_d, 32'h00D0_0E13);
        check("seq2_pc_d", bus.pc_d, 32'h4);
        check("seq2_cnt", bus.fetch_count, 32'd2);
        check("seq2_imem_a", bus.imem_a, 32'h8);

        // Load-use stall for two cycles at pc_f = 8
        drive(1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_imem_a", bus.imem_a, 32'h8);
            check("stall_instr", bus.instr_d, 32'h00D0_0E13);
            check("stall_pc_d", bus.pc_d, 32'h4);
            check("stall_cnt", bus.fetch_count, 32'd2);
        end
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("unstall_pc_d", bus.pc_d, 32'h8);
        check("unstall_instr", bus.instr_d, 32'hA000_0002);
        check("unstall_cnt", bus.fetch_count, 32'd3);
        step(); step(); step();
        check("adv_imem_a", bus.imem_a, 32'h18);
        check("adv_cnt", bus.fetch_count, 32'd6);

        // Taken branch overriding a stall
        drive(1, 1, 0, 1, 32'h08);
        step();
        check("br_imem_a", bus.imem_a, 32'h8);
        check("br_instr", bus.instr_d, NOP);
        check("br_valid", {31'd0, bus.valid_d}, 32'd0);
        check("br_mis", {31'd0, bus.misalign_err}, 32'd0);
        check("br_cnt", bus.fetch_count, 32'd6);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("br2_pc_d", bus.pc_d, 32'h8);
        check("br2_valid", {31'd0, bus.valid_d}, 32'd1);
        check("br2_cnt", bus.fetch_count, 32'd7);

        // Misaligned redirect target
        drive(0, 0, 0, 1, 32'h16);
        step();
        check("mis_imem_a", bus.imem_a, 32'h14);
        check("mis_flag", {31'd0, bus.misalign_err}, 32'd1);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("mis2_pc_d", bus.pc_d, 32'h14);
        check("mis2_instr", bus.instr_d, 32'hA000_0005);
        step();
        check("mis_sticky", {31'd0, bus.misalign_err}, 32'd1);
        check("mis3_cnt", bus.fetch_count, 32'd9);

        // Out-of-range fetch at word 64
        drive(0, 0, 0, 1, 32'h100);
        step();
        check("oob_redir_a", bus.imem_a, 32'h100);
        check("oob_redir_flag", {31'd0, bus.oob_err}, 32'd0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("oob_instr", bus.instr_d, NOP);
        check("oob_valid", {31'd0, bus.valid_d}, 32'd0);
        check("oob_flag", {31'd0, bus.oob_err}, 32'd1);
        check("oob_pc_d", bus.pc_d, 32'h100);
        check("oob_cnt", bus.fetch_count, 32'd9);
        drive(0, 0, 0, 1, 32'h0);
        step();
        check("resume_a", bus.imem_a, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("resume_instr", bus.instr_d, 32'h7FF0_0F13);
        check("resume_valid", {31'd0, bus.valid_d}, 32'd1);
        check("resume_cnt", bus.fetch_count, 32'd10);
        check("oob_sticky", {31'd0, bus.oob_err}, 32'd1);

        // PC+4 wrap from the top of the address space
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        step();
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("wrap_pc_d", bus.pc_d, 32'hFFFF_FFFC);
        check("wrap_pc4_d", bus.pc_plus4_d, 32'h0);
        check("wrap_imem_a", bus.imem_a, 32'h0);
        check("wrap_valid", {31'd0, bus.valid_d}, 32'd0);

        // Flush wins over stall_d; PC still advances
        drive(0, 1, 1, 0, 32'h0);
        step();
        check("flush_instr", bus.instr_d, NOP);
        check("flush_valid", {31'd0, bus.valid_d}, 32'd0);
        check("flush_pc_d", bus.pc_d, 32'h0);
        check("flush_imem_a", bus.imem_a, 32'h4);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("postflush_instr", bus.instr_d, 32'h00D0_0E13);
        check("postflush_cnt", bus.fetch_count, 32'd11);

        // Last in-range word (63)
        drive(0, 0, 0, 1, 32'hFC);
        step();
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("w63_instr", bus.instr_d, 32'hA000_003F);
        check("w63_valid", {31'd0, bus.valid_d}, 32'd1);
        check("w63_cnt", bus.fetch_count, 32'd12);

        // Reset during a stall with a redirect pending
        drive(1, 1, 0, 1, 32'h20);
        reset = 1'b1;
        step();
        check_reset_state("midrst");
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("postrst_instr", bus.instr_d, 32'h7FF0_0F13);
        check("postrst_cnt", bus.fetch_count, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
